led_bar_remapper: RTL and testbench

//  Streaming successor to the combinational remapper. Converts signed controller samples to a centred
//  LED-board position with sign, magnitude, deadzone, clamping and one-hot/bar display modes.
//  3-stage valid/ready pipeline between the input sampler and the game-board LED driver.
//  An optional moving average smooths jitter before mapping.

---
 rtl/led_bar_remapper.sv | 177 +++++++++++++++++
 tb/tb_led_bar_remapper.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bar_remapper.sv
// Streaming signed-sample to LED-board remapper: 3-stage valid/ready pipeline with sign, magnitude,
// deadzone, clamping and one-hot/bar encoding. Define REMAP_AVG_EN to add a moving-average front end.
module led_bar_remapper #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned LEDS     = 10,
  parameter int unsigned DEAD     = 8,
  parameter int unsigned SHIFT    = 4,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   bar_mode,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic        [IN_W-1:0] out_abs,
  output logic                   out_neg,
  output logic        [LEDS-1:0] board_posit
);

  localparam int unsigned HALF = LEDS / 2;
  localparam int unsigned QW   = $clog2(HALF + 1);
  localparam logic [IN_W-1:0] AbsMax = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] NegMin = {1'b1, {(IN_W-1){1'b0}}};

  logic stall, accept;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  logic signed [IN_W-1:0] avg_d;

`ifdef REMAP_AVG_EN
  localparam int unsigned Depth = 2 ** AVG_LOG2;
  localparam int unsigned SW    = IN_W + AVG_LOG2;

  logic signed [IN_W-1:0]     hist_q [Depth];
  logic        [AVG_LOG2-1:0] ptr_q;
  logic signed [SW-1:0]       sum_q, sum_base, oldest, sum_next;

  // Flush zeroes the history before the incoming sample is folded in.
  always_comb begin
    sum_base = flush ? '0 : sum_q;
    oldest   = flush ? '0 : SW'(hist_q[ptr_q]);
    sum_next = sum_base + SW'(in_data) - oldest;
    avg_d    = IN_W'(sum_next >>> AVG_LOG2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) hist_q[i] <= '0;
      ptr_q <= '0;
      sum_q <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < int'(Depth); i++) hist_q[i] <= '0;
      end
      if (accept) begin
        hist_q[ptr_q] <= in_data;
        ptr_q         <= ptr_q + AVG_LOG2'(1);
        sum_q         <= sum_next;
      end else if (flush) begin
        sum_q <= '0;
      end
    end
  end
`else
  logic unused_avg_cfg;
  assign unused_avg_cfg = ^{flush, AVG_LOG2[0]};
  assign avg_d          = in_data;
`endif

  // Stage 1: averaged sample and captured display mode
  logic                   s1_valid_q, s1_bar_q;
  logic signed [IN_W-1:0] s1_avg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_avg_q   <= '0;
      s1_bar_q   <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_avg_q <= avg_d;
        s1_bar_q <= bar_mode;
      end
    end
  end

  // Stage 2: sign, saturated magnitude and clamped step count
  logic            s2_neg_d;
  logic [IN_W-1:0] s2_abs_d, diff, step;
  logic [QW-1:0]   s2_q_d;

  always_comb begin
    s2_neg_d = s1_avg_q[IN_W-1];
    if (s1_avg_q == NegMin) begin
      s2_abs_d = AbsMax;
    end else if (s2_neg_d) begin
      s2_abs_d = -s1_avg_q;
    end else begin
      s2_abs_d = s1_avg_q;
    end
    diff = s2_abs_d - IN_W'(DEAD);
    step = (diff >> SHIFT) + IN_W'(1);
    if (s2_abs_d <= IN_W'(DEAD)) begin
      s2_q_d = '0;
    end else if (step >= IN_W'(HALF)) begin
      s2_q_d = QW'(HALF);
    end else begin
      s2_q_d = QW'(step);
    end
  end

  logic            s2_valid_q, s2_neg_q, s2_bar_q;
  logic [IN_W-1:0] s2_abs_q;
  logic [QW-1:0]   s2_q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_bar_q   <= 1'b0;
      s2_abs_q   <= '0;
      s2_q_q     <= '0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_neg_q <= s2_neg_d;
        s2_bar_q <= s1_bar_q;
        s2_abs_q <= s2_abs_d;
        s2_q_q   <= s2_q_d;
      end
    end
  end

  // Stage 3 encode: bit 0 is the most negative LED; the centre sits between HALF-1 and HALF
  logic [LEDS-1:0] board_d;

  always_comb begin
    int qi, hi;
    qi      = int'(s2_q_q);
    hi      = int'(HALF);
    board_d = '0;
    if (qi != 0) begin
      for (int i = 0; i < int'(LEDS); i++) begin
        if (s2_bar_q) begin
          board_d[i] = s2_neg_q ? (i >= hi - qi && i <= hi - 1)
                                : (i >= hi && i <= hi - 1 + qi);
        end else begin
          board_d[i] = s2_neg_q ? (i == hi - qi) : (i == hi - 1 + qi);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_abs     <= '0;
      out_neg     <= 1'b0;
      board_posit <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid_q;
      if (s2_valid_q) begin
        out_abs     <= s2_abs_q;
        out_neg     <= s2_neg_q;
        board_posit <= board_d;
      end
    end
  end

endmodule

// File: tb/tb_led_bar_remapper.sv
// Directed self-checking bench for led_bar_remapper (default parameters).
// Define REMAP_AVG_EN for both RTL and bench to exercise the averaging front end.
module tb_led_bar_remapper;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] in_data;
  logic               in_valid, in_ready, bar_mode, flush;
  logic               out_valid, out_ready, out_neg;
  logic        [15:0] out_abs;
  logic        [9:0]  board_posit;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_bar_remapper dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bar_mode    (bar_mode),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_abs     (out_abs),
    .out_neg     (out_neg),
    .board_posit (board_posit)
  );

  // Drives one sample, waits (bounded) for its result; latency counts the accepting edge as 1.
  task automatic run_one(input logic signed [15:0] d, input logic bm, input logic fl,
                         output logic seen, output int lat, output logic [15:0] a,
                         output logic n, output logic [9:0] b);
    @(negedge clk);
    in_data = d; bar_mode = bm; flush = fl; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    seen = out_valid; a = out_abs; n = out_neg; b = board_posit;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; bar_mode = 1'b0; flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_vec++;
    if (board_posit !== 10'b0) begin
      n_bad++; $display("FAIL reset_board got %b want 0", board_posit);
    end
    n_vec++;
    if (out_abs !== 16'd0 || out_neg !== 1'b0) begin
      n_bad++; $display("FAIL reset_abs_neg got %0d/%b want 0/0", out_abs, out_neg);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_onehot_pos();
    logic seen, n; int lat; logic [15:0] a; logic [9:0] b;
    run_one(16'sd85, 1'b0, 1'b0, seen, lat, a, n, b);
    n_vec++;
    if (seen !== 1'b1 || lat !== 3) begin
      n_bad++; $display("FAIL onehot_latency got seen=%b lat=%0d want seen=1 lat=3", seen, lat);
    end
    n_vec++;
    if (a !== 16'd85) begin n_bad++; $display("FAIL onehot_abs got %0d want 85", a); end
    n_vec++;
    if (n !== 1'b0) begin n_bad++; $display("FAIL onehot_neg got %b want 0", n); end
    n_vec++;
    if (b !== 10'b1000000000) begin
      n_bad++; $display("FAIL onehot_board got %b want 1000000000", b);
    end
  endtask

  task automatic test_bar_neg();
    logic seen, n; int lat; logic [15:0] a; logic [9:0] b;
    run_one(-16'sd35, 1'b1, 1'b0, seen, lat, a, n, b);
    n_vec++;
    if (seen !== 1'b1 || a !== 16'd35 || n !== 1'b1) begin
      n_bad++; $display("FAIL bar_abs_neg got seen=%b abs=%0d neg=%b want 1/35/1", seen, a, n);
    end
    n_vec++;
    if (b !== 10'b0000011000) begin
      n_bad++; $display("FAIL bar_board got %b want 0000011000", b);
    end
    // Bar in the positive direction: 200 -> q clamps to 5, bits 5..9.
    run_one(16'sd200, 1'b1, 1'b0, seen, lat, a, n, b);
    n_vec++;
    if (b !== 10'b1111100000 || n !== 1'b0) begin
      n_bad++; $display("FAIL bar_pos_board got %b/%b want 1111100000/0", b, n);
    end
  endtask

  task automatic test_saturate_deadzone();
    logic seen, n; int lat; logic [15:0] a; logic [9:0] b;
    run_one(-16'sd32768, 1'b0, 1'b0, seen, lat, a, n, b);
    n_vec++;
    if (a !== 16'd32767 || n !== 1'b1) begin
      n_bad++; $display("FAIL sat_abs_neg got %0d/%b want 32767/1", a, n);
    end
    n_vec++;
    if (b !== 10'b0000000001) begin
      n_bad++; $display("FAIL sat_board got %b want 0000000001", b);
    end
    run_one(16'sd5, 1'b0, 1'b0, seen, lat, a, n, b);
    n_vec++;
    if (b !== 10'b0 || n !== 1'b0 || a !== 16'd5) begin
      n_bad++; $display("FAIL dead_pos got %b/%b/%0d want 0/0/5", b, n, a);
    end
    run_one(-16'sd5, 1'b0, 1'b0, seen, lat, a, n, b);
    n_vec++;
    if (b !== 10'b0 || n !== 1'b1) begin
      n_bad++; $display("FAIL dead_neg got %b/%b want 0/1", b, n);
    end
    // Just past the deadzone: 9 -> q=1, one-hot bit 5.
    run_one(16'sd9, 1'b0, 1'b0, seen, lat, a, n, b);
    n_vec++;
    if (b !== 10'b0000100000) begin
      n_bad++; $display("FAIL dead_edge got %b want 0000100000", b);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] stim [5];
    logic        [15:0] got [$];
    int idx;
    logic fire_in, fire_out;
    stim = '{16'sd85, 16'sd65, 16'sd45, 16'sd25, 16'sd5};
    idx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      in_valid  = (idx < 5);
      in_data   = (idx < 5) ? stim[idx] : 16'sd0;
      bar_mode  = 1'b0;
      out_ready = !(cyc >= 4 && cyc <= 7);
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (cyc >= 4 && cyc <= 7) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_bad++; $display("FAIL stall_in_ready cycle %0d got %b want 0", cyc, in_ready);
        end
      end
      if (fire_out) got.push_back(out_abs);
      if (fire_in) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++;
    if (got.size() != 5) begin
      n_bad++; $display("FAIL stream_count got %0d want 5", got.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= got.size()) begin
        n_bad++; $display("FAIL stream_order[%0d] got none want %0d", i, stim[i]);
      end else if (got[i] !== 16'(stim[i])) begin
        n_bad++; $display("FAIL stream_order[%0d] got %0d want %0d", i, got[i], stim[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int seen_cnt;
    seen_cnt = 0;
    @(negedge clk);
    in_data = 16'sd85; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_cnt++;
    end
    n_vec++;
    if (seen_cnt != 0) begin
      n_bad++; $display("FAIL midreset_discard got %0d outputs want 0", seen_cnt);
    end
  endtask

`ifdef REMAP_AVG_EN
  task automatic test_average();
    logic seen, n; int lat; logic [15:0] a; logic [9:0] b;
    logic [15:0] exp_abs [4];
    exp_abs = '{16'd10, 16'd20, 16'd30, 16'd40};
    for (int i = 0; i < 4; i++) begin
      run_one(16'sd40, 1'b0, 1'b0, seen, lat, a, n, b);
      n_vec++;
      if (a !== exp_abs[i]) begin
        n_bad++; $display("FAIL avg_fill[%0d] got %0d want %0d", i, a, exp_abs[i]);
      end
    end
    run_one(-16'sd40, 1'b0, 1'b1, seen, lat, a, n, b);
    n_vec++;
    if (a !== 16'd10 || n !== 1'b1 || b !== 10'b0000010000) begin
      n_bad++;
      $display("FAIL avg_flush got %0d/%b/%b want 10/1/0000010000", a, n, b);
    end
  endtask
`else
  task automatic test_flush_ignored();
    logic seen, n; int lat; logic [15:0] a; logic [9:0] b;
    run_one(16'sd40, 1'b0, 1'b1, seen, lat, a, n, b);
    n_vec++;
    if (a !== 16'd40 || b !== 10'b0010000000) begin
      n_bad++; $display("FAIL flush_ignored got %0d/%b want 40/0010000000", a, b);
    end
    n_vec++;
    if (lat !== 3) begin n_bad++; $display("FAIL flush_latency got %0d want 3", lat); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef REMAP_AVG_EN
    test_average();
`else
    test_onehot_pos();
    test_bar_neg();
    test_saturate_deadzone();
    test_back_to_back();
    test_flush_ignored();
`endif
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
